print_uart_tx: RTL and testbench

Serial console transmitter that consumes the 49-bit `print_out` word stream produced by the PicoRV32 wrapper's console-capture logic. It sits on the consumer side of that interface. Each valid word carries one character. The block buffers characters in a small FIFO and shifts them out on a single 8N1 UART line so firmware console output reaches an external terminal. Overflow is reported, never back-pressured, because the `print_out` producer has no ready input.

---
 rtl/print_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_print_uart_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/print_uart_tx.sv
// Console byte transmitter: buffers print_out characters in a small FIFO and
// shifts them out as 8N1 UART frames. Overflow drops words and is reported, never back-pressured.
module print_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [48:0]        print_in,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int unsigned Depth  = 2 ** FIFO_AW;
  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0]  TimerMax = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                busy_q;
  logic                ovf_q;
  logic [15:0]         drops_q;
  logic [FIFO_AW-1:0]  wptr_q, rptr_q;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [7:0]          mem_q [Depth];

  logic valid, full, push, pop, drop;
  logic unused_print_bits;

  assign unused_print_bits = ^print_in[47:8];

  assign valid = print_in[48];
  // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a word.
  assign full  = (count_q == DepthCnt);
  assign push  = valid & ~full;
  assign drop  = valid & full;
  assign pop   = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          timer_d = '0;
          shift_d = mem_q[rptr_q];
        end
      end
      StStart: begin
        if (timer_q == TimerMax) begin
          state_d = StData;
          timer_d = '0;
          bit_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == TimerMax) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_q == TimerMax) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the next state so txd changes on the same edge as the FSM.
    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != StIdle) || (count_q != '0);
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drops_q != 16'hFFFF) begin
          drops_q <= drops_q + 16'd1;
        end
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= print_in[7:0];
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drops_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Bench for print_uart_tx: a queue-and-frame-position reference model plus an
// independent line decoder, exercised by directed scenarios and random traffic.
module tb_print_uart_tx;

  localparam int C     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic          clk = 1'b0;
  logic          resetn;
  logic [48:0]   print_in;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  print_uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_AW      (AW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .print_in   (print_in),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, position within the current frame (-1 = idle).
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  int         m_pos = -1;
  logic [7:0] m_cur = '0;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_drops = 0;

  // Line decoder state.
  logic [7:0] rx[$];
  int         gaps[$];
  int         cyc = 0;
  int         rx_cnt = 0;
  int         last_end = 0;
  int         stop_err = 0;
  bit         rx_on = 0;
  bit         have_end = 0;
  logic [7:0] rx_byte = '0;

  function automatic logic model_txd();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic drive(input bit v, input logic [7:0] d);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    print_in = {v, r[39:0], d};
  endtask

  task automatic tick();
    int   sz;
    logic was_busy;
    @(posedge clk);
    if (!resetn) begin
      m_q.delete();
      m_pos   = -1;
      m_busy  = 1'b0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      sz       = m_q.size();
      was_busy = (m_pos >= 0) || (sz != 0);
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end else if (sz != 0) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_pos = 0;
      end
      if (print_in[48]) begin
        if (sz == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_q.push_back(print_in[7:0]);
        end
      end
      m_busy = was_busy;
    end
    #1;
    cyc++;
    if (!resetn) begin
      rx_on = 0;
    end else if (!rx_on && txd === 1'b0) begin
      rx_on  = 1;
      rx_cnt = 0;
      if (have_end) gaps.push_back(cyc - last_end - 1);
    end
    if (rx_on) begin
      if (rx_cnt % C == C / 2) begin
        if (rx_cnt / C == 0 && txd !== 1'b0) stop_err++;
        if (rx_cnt / C >= 1 && rx_cnt / C <= 8) rx_byte[rx_cnt/C-1] = txd;
        if (rx_cnt / C == 9 && txd !== 1'b1) stop_err++;
      end
      if (rx_cnt == FRAME - 1) begin
        rx_on    = 0;
        rx.push_back(rx_byte);
        last_end = cyc;
        have_end = 1;
      end else begin
        rx_cnt++;
      end
    end
  endtask

  task automatic clear_logs();
    rx.delete();
    m_sent.delete();
    gaps.delete();
    have_end = 0;
    stop_err = 0;
  endtask

  // Advances time, tallying any cycle where the DUT disagrees with the model.
  task automatic run(input int n_max, input bit until_idle, output int mism, output bit timeout);
    int n;
    n       = 0;
    mism    = 0;
    timeout = 0;
    forever begin
      if (until_idle && m_pos < 0 && m_q.size() == 0 && !rx_on && !m_busy) break;
      if (n >= n_max) begin
        timeout = until_idle;
        break;
      end
      tick();
      n++;
      if (txd !== model_txd() || fifo_count !== m_q.size() || busy !== m_busy ||
          overflow !== m_ovf || drop_count !== m_drops) mism++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, 8'h00);
    tick();
    tick();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (fifo_count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++;
    if (drop_count !== 0) begin errors++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [9:0] pat;
    int mism, pmis;
    bit to;
    pat  = 10'b1010000010;
    pmis = 0;
    clear_logs();
    drive(1'b1, 8'h41);
    tick();
    drive(1'b0, 8'($urandom()));
    checks++;
    if (fifo_count !== 1) begin errors++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", txd); end
    tick();
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL single_start: got %b want 0", txd); end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      if (txd !== pat[i/C] || busy !== 1'b1) pmis++;
    end
    checks++; if (pmis !== 0) begin errors++; $display("FAIL single_pattern: got %0d bad cycles want 0", pmis); end
    run(200, 1'b1, mism, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_drain: got timeout want idle"); end
    checks++; if (mism !== 0) begin errors++; $display("FAIL single_model: got %0d bad cycles want 0", mism); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    checks++;
    if (rx.size() != 1 || rx[0] !== 8'h41) begin
      errors++; $display("FAIL single_rx: got %0d frames want one 41", rx.size());
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3];
    int peak, mism;
    bit to;
    bytes = '{8'h00, 8'hFF, 8'h55};
    peak  = 0;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bytes[i]);
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    drive(1'b0, 8'h00);
    run(500, 1'b1, mism, to);
    checks++; if (peak !== 2) begin errors++; $display("FAIL burst_peak: got %0d want 2", peak); end
    checks++; if (to || mism !== 0) begin errors++; $display("FAIL burst_model: got %0d bad cycles (timeout %0d) want 0", mism, to); end
    checks++; if (rx.size() != 3) begin errors++; $display("FAIL burst_frames: got %0d want 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== bytes[i]) begin errors++; $display("FAIL burst_byte%0d: got %h want %h", i, rx[i], bytes[i]); end
    end
    checks++;
    if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1) begin
      errors++; $display("FAIL burst_gap: got %0d gaps (first %0d) want two of 1", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    end
    checks++; if (stop_err !== 0) begin errors++; $display("FAIL burst_framing: got %0d errors want 0", stop_err); end
  endtask

  task automatic test_ignore();
    int mism;
    mism = 0;
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      print_in = {1'b0, 40'hFF_FFFF_FFFF, 8'h7E};
      tick();
      if (txd !== 1'b1 || fifo_count !== 0 || busy !== 1'b0) mism++;
    end
    checks++; if (mism !== 0) begin errors++; $display("FAIL ignore_idle: got %0d bad cycles want 0", mism); end
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL ignore_rx: got %0d frames want 0", rx.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0] words [7];
    int mism;
    bit to;
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      words[i] = 8'($urandom());
      drive(1'b1, words[i]);
      tick();
    end
    drive(1'b0, 8'h00);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (drop_count !== 2) begin errors++; $display("FAIL ovf_drops: got %0d want 2", drop_count); end
    checks++; if (fifo_count !== 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    run(1000, 1'b1, mism, to);
    checks++; if (to || mism !== 0) begin errors++; $display("FAIL ovf_model: got %0d bad cycles (timeout %0d) want 0", mism, to); end
    checks++; if (rx.size() != 5) begin errors++; $display("FAIL ovf_frames: got %0d want 5", rx.size()); end
    for (int i = 0; i < 5 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== words[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx[i], words[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] words [10];
    int mism, tot;
    bit to;
    tot = 0;
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      words[i] = 8'($urandom());
      drive(1'b1, words[i]);
      tick();
      drive(1'b0, 8'h00);
      run(34, 1'b0, mism, to);
      tot += mism;
    end
    run(1000, 1'b1, mism, to);
    tot += mism;
    checks++; if (to || tot !== 0) begin errors++; $display("FAIL wrap_model: got %0d bad cycles (timeout %0d) want 0", tot, to); end
    checks++; if (drop_count !== 2) begin errors++; $display("FAIL wrap_drops: got %0d want 2", drop_count); end
    checks++; if (rx.size() != 10) begin errors++; $display("FAIL wrap_frames: got %0d want 10", rx.size()); end
    for (int i = 0; i < 10 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== words[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx[i], words[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, mism;
    bit to;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom()));
      tick();
    end
    drive(1'b0, 8'h00);
    n = 0;
    while (m_pos != 4 * C + 1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL rst_mid_reach: got timeout want data bit 3"); end
    checks++; if (fifo_count !== 2) begin errors++; $display("FAIL rst_mid_queued: got %0d want 2", fifo_count); end
    resetn = 1'b0;
    tick();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b want 1", txd); end
    checks++; if (fifo_count !== 0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", overflow); end
    checks++; if (drop_count !== 0) begin errors++; $display("FAIL rst_mid_drops: got %0d want 0", drop_count); end
    resetn = 1'b1;
    clear_logs();
    run(100, 1'b0, mism, to);
    checks++; if (mism !== 0) begin errors++; $display("FAIL rst_mid_after: got %0d bad cycles want 0", mism); end
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL rst_mid_rx: got %0d frames want 0", rx.size()); end
  endtask

  task automatic test_random();
    int rate, mism;
    bit to, v;
    clear_logs();
    rate = 10;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rate = $urandom_range(1, 40);
      v = ($urandom_range(1, rate) == 1);
      drive(v, 8'($urandom()));
      tick();
      checks++;
      if (txd !== model_txd() || fifo_count !== m_q.size() || busy !== m_busy ||
          overflow !== m_ovf || drop_count !== m_drops) begin
        errors++;
        $display("FAIL rand_cycle%0d: got txd=%b cnt=%0d busy=%b ovf=%b drops=%0d want %b %0d %b %b %0d",
                 i, txd, fifo_count, busy, overflow, drop_count,
                 model_txd(), m_q.size(), m_busy, m_ovf, m_drops);
      end
    end
    drive(1'b0, 8'h00);
    run(2000, 1'b1, mism, to);
    checks++; if (to || mism !== 0) begin errors++; $display("FAIL rand_drain: got %0d bad cycles (timeout %0d) want 0", mism, to); end
    checks++; if (rx.size() != m_sent.size()) begin errors++; $display("FAIL rand_frames: got %0d want %0d", rx.size(), m_sent.size()); end
    mism = 0;
    for (int i = 0; i < rx.size() && i < m_sent.size(); i++) if (rx[i] !== m_sent[i]) mism++;
    checks++; if (mism !== 0) begin errors++; $display("FAIL rand_order: got %0d wrong bytes want 0", mism); end
    checks++; if (stop_err !== 0) begin errors++; $display("FAIL rand_framing: got %0d errors want 0", stop_err); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    print_in = '0;
    test_reset();
    test_single();
    test_burst();
    test_ignore();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
